id_pipe_stage: RTL and testbench

//  Registered RV32I integer-ALU decode stage: decodes OP-IMM, OP, LUI and AUIPC, reads the

---
 rtl/id_pipe_stage.sv | 123 ++++++++++++
 tb/tb_id_pipe_stage.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: RV32I integer-ALU decode stage with EX/MEM bypass and a valid/ready ID/EX register.
module id_pipe_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5,
  parameter bit FWD_EN  = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        pc_i,
  input  logic [31:0]        inst_i,
  output logic               reg1_read_o,
  output logic               reg2_read_o,
  output logic [RADDR_W-1:0] reg1_addr_o,
  output logic [RADDR_W-1:0] reg2_addr_o,
  input  logic [XLEN-1:0]    reg1_data_i,
  input  logic [XLEN-1:0]    reg2_data_i,
  input  logic               ex_wreg_i,
  input  logic [RADDR_W-1:0] ex_wd_i,
  input  logic [XLEN-1:0]    ex_wdata_i,
  input  logic               mem_wreg_i,
  input  logic [RADDR_W-1:0] mem_wd_i,
  input  logic [XLEN-1:0]    mem_wdata_i,
  input  logic               flush_i,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         aluop_o,
  output logic [2:0]         alusel_o,
  output logic [XLEN-1:0]    reg1_o,
  output logic [XLEN-1:0]    reg2_o,
  output logic [RADDR_W-1:0] wd_o,
  output logic               wreg_o,
  output logic [31:0]        pc_o,
  output logic               illegal_o
);
  localparam logic [6:0] OPI = 7'b0010011, OPR = 7'b0110011, LUI = 7'b0110111, AUI = 7'b0010111;
  localparam logic [6:0] ALT = 7'b0100000;
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [7:0] base, op;
  logic [2:0] sel;
  logic legal, shift, take;
  logic [XLEN-1:0] imm, fwd1, fwd2, src1, src2;
  assign opc = inst_i[6:0];
  assign f3 = inst_i[14:12];
  assign f7 = inst_i[31:25];
  assign reg1_read_o = opc == OPI || opc == OPR;
  assign reg2_read_o = opc == OPR;
  assign reg1_addr_o = RADDR_W'(inst_i[19:15]);
  assign reg2_addr_o = RADDR_W'(inst_i[24:20]);
  always_comb begin
    case (f3)
      3'd0: base = 8'h01;
      3'd1: base = 8'h03;
      3'd2: base = 8'h04;
      3'd3: base = 8'h05;
      3'd4: base = 8'h06;
      3'd5: base = 8'h07;
      3'd6: base = 8'h09;
      default: base = 8'h0A;
    endcase
  end
  always_comb begin
    legal = 1'b0;
    op = 8'h00;
    if (opc == OPI) begin
      legal = f3 == 3'd1 ? f7 == 7'd0 : f3 == 3'd5 ? (f7 == 7'd0 || f7 == ALT) : 1'b1;
      op = (f3 == 3'd5 && f7 == ALT) ? 8'h08 : base;
    end else if (opc == OPR) begin
      legal = f7 == 7'd0 || (f7 == ALT && (f3 == 3'd0 || f3 == 3'd5));
      op = f7 == ALT ? (f3 == 3'd0 ? 8'h02 : 8'h08) : base;
    end else if (opc == LUI || opc == AUI) begin
      legal = 1'b1;
      op = 8'h01;
    end
    op = legal ? op : 8'h00;
  end
  assign sel = op == 8'h00 ? 3'd0 :
               (op == 8'h06 || op == 8'h09 || op == 8'h0A) ? 3'd1 :
               (op == 8'h03 || op == 8'h07 || op == 8'h08) ? 3'd2 : 3'd3;
  // Shift immediates carry only shamt; funct7 bits are opcode, not value.
  assign shift = opc == OPI && (f3 == 3'd1 || f3 == 3'd5);
  assign imm = (opc == LUI || opc == AUI) ? XLEN'($signed({inst_i[31:12], 12'b0})) :
               shift ? XLEN'(inst_i[24:20]) : XLEN'($signed(inst_i[31:20]));
  assign fwd1 = reg1_addr_o == '0 ? '0 :
                (FWD_EN && ex_wreg_i && ex_wd_i == reg1_addr_o) ? ex_wdata_i :
                (FWD_EN && mem_wreg_i && mem_wd_i == reg1_addr_o) ? mem_wdata_i : reg1_data_i;
  assign fwd2 = reg2_addr_o == '0 ? '0 :
                (FWD_EN && ex_wreg_i && ex_wd_i == reg2_addr_o) ? ex_wdata_i :
                (FWD_EN && mem_wreg_i && mem_wd_i == reg2_addr_o) ? mem_wdata_i : reg2_data_i;
  assign src1 = reg1_read_o ? fwd1 : opc == AUI ? XLEN'(pc_i) : '0;
  assign src2 = reg2_read_o ? fwd2 : imm;
  assign in_ready = !rst && (!out_valid || out_ready);
  assign take = in_valid && in_ready && !flush_i;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      aluop_o <= 8'h00;
      alusel_o <= 3'd0;
      reg1_o <= '0;
      reg2_o <= '0;
      wd_o <= '0;
      wreg_o <= 1'b0;
      pc_o <= '0;
      illegal_o <= 1'b0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid <= 1'b1;
      aluop_o <= op;
      alusel_o <= sel;
      reg1_o <= src1;
      reg2_o <= src2;
      wd_o <= RADDR_W'(inst_i[11:7]);
      wreg_o <= legal && inst_i[11:7] != 5'd0;
      pc_o <= pc_i;
      illegal_o <= !legal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_id_pipe_stage.sv
// tb_id_pipe_stage: scoreboard bench for the decode stage against a mnemonic-level reference model.
module tb_id_pipe_stage;
  typedef struct packed {
    logic [7:0] aluop;
    logic [2:0] alusel;
    logic [31:0] r1, r2;
    logic [4:0] wd;
    logic wreg;
    logic [31:0] pc;
    logic ill;
  } exp_t;
  localparam logic [7:0] BASE [8] = '{8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h09, 8'h0A};
  logic clk = 0, rst = 1, in_valid = 0, in_ready, flush_i = 0, out_valid, out_ready = 0;
  logic [31:0] pc_i = 0, inst_i = 0, reg1_data_i, reg2_data_i, ex_wdata_i = 0, mem_wdata_i = 0;
  logic reg1_read_o, reg2_read_o, ex_wreg_i = 0, mem_wreg_i = 0, wreg_o, illegal_o;
  logic [4:0] reg1_addr_o, reg2_addr_o, ex_wd_i = 0, mem_wd_i = 0, wd_o;
  logic [7:0] aluop_o;
  logic [2:0] alusel_o;
  logic [31:0] reg1_o, reg2_o, pc_o;
  logic [31:0] rf [32];
  logic b_ew = 0, b_mw = 0;
  logic [4:0] b_ed = 0, b_md = 0;
  logic [31:0] b_edat = 0, b_mdat = 0;
  exp_t q[$];
  bit mv = 0;
  int total = 0, bad = 0;
  id_pipe_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
    .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o),
    .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_wreg_i(ex_wreg_i), .ex_wd_i(ex_wd_i), .ex_wdata_i(ex_wdata_i),
    .mem_wreg_i(mem_wreg_i), .mem_wd_i(mem_wd_i), .mem_wdata_i(mem_wdata_i),
    .flush_i(flush_i), .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o),
    .alusel_o(alusel_o), .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o),
    .pc_o(pc_o), .illegal_o(illegal_o)
  );
  always #5 clk = ~clk;
  assign reg1_data_i = rf[inst_i[19:15]];
  assign reg2_data_i = rf[inst_i[24:20]];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, got, want, $time);
    end
  endtask
  function automatic logic [31:0] src(input logic [4:0] r);
    if (r == 0) return 32'd0;
    if (ex_wreg_i && ex_wd_i == r) return ex_wdata_i;
    if (mem_wreg_i && mem_wd_i == r) return mem_wdata_i;
    return rf[r];
  endfunction
  function automatic exp_t mk(input logic [7:0] op, input logic [2:0] s, input logic [31:0] a, b,
                              input logic [4:0] wd, input logic w, input logic [31:0] pc, input logic ill);
    exp_t e;
    e.aluop = op; e.alusel = s; e.r1 = a; e.r2 = b; e.wd = wd; e.wreg = w; e.pc = pc; e.ill = ill;
    return e;
  endfunction
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc);
    logic [2:0] f3;
    logic [6:0] f7;
    logic legal;
    logic [7:0] op;
    logic [2:0] s;
    logic [31:0] a, b;
    f3 = ins[14:12]; f7 = ins[31:25]; legal = 0; op = 0; a = 0; b = 0;
    case (ins[6:0])
      7'h13: begin
        a = src(ins[19:15]);
        if (f3 == 1 || f3 == 5) begin
          b = {27'd0, ins[24:20]};
          legal = f7 == 0 || (f3 == 5 && f7 == 7'h20);
          op = f7 == 7'h20 ? 8'h08 : BASE[f3];
        end else begin
          b = 32'($signed(ins[31:20]));
          legal = 1;
          op = BASE[f3];
        end
      end
      7'h33: begin
        a = src(ins[19:15]);
        b = src(ins[24:20]);
        if (f7 == 0) begin legal = 1; op = BASE[f3]; end
        else if (f7 == 7'h20 && f3 == 0) begin legal = 1; op = 8'h02; end
        else if (f7 == 7'h20 && f3 == 5) begin legal = 1; op = 8'h08; end
      end
      7'h37: begin b = {ins[31:12], 12'd0}; legal = 1; op = 8'h01; end
      7'h17: begin a = pc; b = {ins[31:12], 12'd0}; legal = 1; op = 8'h01; end
      default: ;
    endcase
    if (!legal) op = 0;
    s = op == 0 ? 3'd0 : (op inside {8'h06, 8'h09, 8'h0A}) ? 3'd1 : (op inside {8'h03, 8'h07, 8'h08}) ? 3'd2 : 3'd3;
    return mk(op, s, a, b, ins[11:7], legal && ins[11:7] != 0, pc, !legal);
  endfunction
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic fl,
                       input logic ordy, input logic lit_en, input exp_t lit);
    @(posedge clk); #1;
    in_valid = v; inst_i = ins; pc_i = pc; flush_i = fl; out_ready = ordy;
    ex_wreg_i = b_ew; ex_wd_i = b_ed; ex_wdata_i = b_edat;
    mem_wreg_i = b_mw; mem_wd_i = b_md; mem_wdata_i = b_mdat;
    #1;
    if (v && !fl && !rst && (!mv || ordy)) q.push_back(lit_en ? lit : model(ins, pc));
  endtask
  task automatic cmp(input exp_t e);
    chk("aluop", 32'(aluop_o), 32'(e.aluop));
    chk("alusel", 32'(alusel_o), 32'(e.alusel));
    chk("wd", 32'(wd_o), 32'(e.wd));
    chk("wreg", 32'(wreg_o), 32'(e.wreg));
    chk("pc", pc_o, e.pc);
    chk("illegal", 32'(illegal_o), 32'(e.ill));
    if (!e.ill) begin
      chk("reg1", reg1_o, e.r1);
      chk("reg2", reg2_o, e.r2);
    end
  endtask
  // Monitor: reset values, handshake, stall stability and in-order payload check.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_payload", {aluop_o, 5'd0, alusel_o, wd_o, wreg_o, illegal_o, 8'd0}, 0);
      chk("rst_ops", reg1_o | reg2_o | pc_o, 0);
      q.delete();
      mv = 0;
    end else begin
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("in_ready", 32'(in_ready), 32'(!mv || out_ready));
      if (mv && q.size() == 0) chk("sb_empty", 0, 1);
      else if (flush_i) begin
        if (mv) void'(q.pop_front());
      end else if (mv) begin
        cmp(q[0]);
        if (out_ready) void'(q.pop_front());
      end
      mv = q.size() != 0;
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    exp_t z;
    logic [31:0] ins;
    logic [6:0] opc, f7;
    int k;
    z = '0;
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEADBEEF;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    drive(1, 32'h00A00093, 32'h4, 0, 0, 0, z);
    drive(0, 0, 0, 0, 0, 0, z);
    @(posedge clk); #1 rst = 1; in_valid = 0;
    @(posedge clk); @(posedge clk); #1 rst = 0;
    drive(1, 32'hFFF00293, 32'h0, 0, 1, 1, mk(8'h01, 3, 0, 32'hFFFFFFFF, 5, 1, 0, 0));
    b_ew = 1; b_ed = 2; b_edat = 32'hAA; b_mw = 1; b_md = 2; b_mdat = 32'hBB;
    drive(1, 32'h0F016093, 32'h8, 0, 1, 1, mk(8'h09, 1, 32'hAA, 32'hF0, 1, 1, 32'h8, 0));
    b_ew = 0; b_mw = 0;
    drive(1, 32'h402081B3, 32'hC, 0, 1, 1, mk(8'h02, 3, rf[1], rf[2], 3, 1, 32'hC, 0));
    repeat (3) drive(1, 32'hFFF00293, 32'h10, 0, 0, 0, z);
    drive(0, 0, 0, 0, 1, 0, z);
    drive(1, 32'h00A00093, 32'h14, 0, 0, 0, z);
    drive(1, 32'h00B00093, 32'h18, 1, 0, 0, z);
    drive(1, 32'h00001217, 32'h100, 0, 1, 1, mk(8'h01, 3, 32'h100, 32'h1000, 4, 1, 32'h100, 0));
    drive(1, 32'h400062B3, 32'h20, 0, 1, 1, mk(0, 0, 0, 0, 5, 0, 32'h20, 1));
    drive(1, 32'h00208033, 32'h24, 0, 1, 1, mk(8'h01, 3, rf[1], rf[2], 0, 0, 32'h24, 0));
    for (int i = 0; i < 1500; i++) begin
      b_ew = 1'($urandom); b_ed = 5'($urandom_range(0, 7)); b_edat = $urandom;
      b_mw = 1'($urandom); b_md = 5'($urandom_range(0, 7)); b_mdat = $urandom;
      k = $urandom_range(0, 9);
      opc = k < 4 ? 7'h13 : k < 7 ? 7'h33 : k == 7 ? 7'h37 : k == 8 ? 7'h17 : 7'($urandom);
      k = $urandom_range(0, 3);
      f7 = k == 0 ? 7'h00 : k == 1 ? 7'h20 : 7'($urandom);
      ins = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
             5'($urandom_range(0, 7)), opc};
      drive($urandom_range(0, 3) != 0, ins, $urandom, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, 0, z);
    end
    b_ew = 0; b_mw = 0;
    repeat (3) drive(0, 0, 0, 0, 1, 0, z);
    chk("sb_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
